// File: rtl/rt_pkg.sv
// Shared types and constants for the random-word arbiter slice.
package rt_pkg;

  // One generator sample.
  typedef logic [63:0] fixed_real;

  // Width of each per-requester burst-length field.
  localparam int unsigned REQ_LEN_W = 2;

  // Reload value of the optional whitening LFSR.
  localparam fixed_real RAND_LFSR_SEED = 64'h1;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first set request bit at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any,
  output logic [IDX_W-1:0]   win
);

  // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
  always_comb begin : p_pick
    int unsigned pos;
    any = 1'b0;
    win = '0;
    pos = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = 32'(rr_ptr) + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!any && req[pos[IDX_W-1:0]]) begin
        any = 1'b1;
        win = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// Grants the shared 64-bit random-word generator to one requester at a time for a
// burst of 1-3 consecutive words, round-robin fair, with one idle bubble between bursts.
// Optional feature: define RAND_ARB_WHITEN_EN to XOR each delivered word with a 64-bit
// LFSR that advances only on delivered words.
module rand_arbiter
  import rt_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [63:0]                    rand_in,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*REQ_LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           out_valid,
  output logic [63:0]                    out_data,
  output logic [1:0]                     out_idx,
  output logic                           out_last,
  output logic                           busy
);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [REQ_LEN_W-1:0]   len_q, len_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   valid_q, valid_d;
  fixed_real              data_q, data_d;
  logic [1:0]             idx_q, idx_d;
  logic                   last_q, last_d;

  logic                   pick_any;
  logic [IDX_W-1:0]       pick_win;
  logic [REQ_LEN_W-1:0]   pick_len;
  logic                   more;
  fixed_real              word;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .win    (pick_win)
  );

  // Requested length of the prospective winner; a zero field means a single word.
  always_comb begin
    pick_len = req_len[pick_win*REQ_LEN_W +: REQ_LEN_W];
    if (pick_len == '0) begin
      pick_len = REQ_LEN_W'(1);
    end
  end

  // Another word remains in the current burst after the one now on the outputs.
  assign more = ({1'b0, idx_q} + 3'd1) < {1'b0, len_q};

`ifdef RAND_ARB_WHITEN_EN
  fixed_real lfsr_q, lfsr_d;
  logic      deliver;

  assign word    = rand_in ^ lfsr_q;
  assign deliver = ((state_q == IDLE) && pick_any) || ((state_q == BURST) && more);

  // Whitening LFSR steps once per delivered word only.
  always_comb begin
    lfsr_d = lfsr_q;
    if (deliver) begin
      lfsr_d = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
    end
  end

  // LFSR register, reloaded on reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr_q <= RAND_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign word = rand_in;
`endif

  // FSM next state and next output values; outputs default to the idle (all-zero) pattern.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    len_d    = len_q;
    grant_d  = '0;
    valid_d  = 1'b0;
    data_d   = '0;
    idx_d    = '0;
    last_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          win_d   = pick_win;
          len_d   = pick_len;
          grant_d = NUM_REQ'(1) << pick_win;
          valid_d = 1'b1;
          data_d  = word;
          last_d  = (pick_len == REQ_LEN_W'(1));
        end
      end
      BURST: begin
        if (more) begin
          grant_d = grant_q;
          valid_d = 1'b1;
          data_d  = word;
          idx_d   = idx_q + 2'd1;
          last_d  = ({1'b0, idx_q} + 3'd2) == {1'b0, len_q};
        end else begin
          // Burst done: one bubble cycle, then the pointer moves past the winner.
          state_d  = IDLE;
          rr_ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      len_q    <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      len_q    <= len_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

  assign grant     = grant_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_rand_arbiter.sv
// Self-checking bench for rand_arbiter (NUM_REQ = 4) using an expected-output queue.
module tb_rand_arbiter;

  logic        Clk;
  logic        Reset;
  logic [63:0] rand_in;
  logic [3:0]  req;
  logic [7:0]  req_len;
  logic [3:0]  grant;
  logic        out_valid;
  logic [63:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;

  typedef struct packed {
    logic [3:0]  grant;
    logic        valid;
    logic [1:0]  idx;
    logic        last;
    logic        busy;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  exp_t        obs;
  int          checks;
  int          failures;
  logic [63:0] tb_lfsr;

  rand_arbiter #(
    .NUM_REQ (4)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .rand_in   (rand_in),
    .req       (req),
    .req_len   (req_len),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected word for a delivered sample, advancing the whitening model when enabled.
  function automatic logic [63:0] deliver(input logic [63:0] r);
    logic [63:0] d;
`ifdef RAND_ARB_WHITEN_EN
    d = r ^ tb_lfsr;
    tb_lfsr = {tb_lfsr[62:0], tb_lfsr[63] ^ tb_lfsr[62] ^ tb_lfsr[60] ^ tb_lfsr[59]};
`else
    d = r;
`endif
    return d;
  endfunction

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] idx, input logic last,
                              input logic [63:0] d);
    exp_t x;
    x.grant = g;
    x.valid = |g;
    x.idx   = idx;
    x.last  = last;
    x.busy  = |g;
    x.data  = d;
    return x;
  endfunction

  task automatic new_word();
    rand_in = {$urandom(), $urandom()};
  endtask

  // Let the DUT take one edge and sample just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
    obs = {grant, out_valid, out_idx, out_last, busy, out_data};
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    req = '0;
    req_len = '0;
    tb_lfsr = 64'h1;
    for (int k = 0; k < 3; k++) begin
      new_word();
      sb.push_back(mk(4'b0000, 2'd0, 1'b0, 64'h0));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset cyc%0d got=%h want=%h", k, obs, e);
      end
    end
    Reset = 1'b0;
  endtask

  // Three-word burst for requester 0; req dropped mid-burst must not abort it.
  task automatic test_burst3();
    req = 4'b0001;
    req_len = {2'd1, 2'd1, 2'd1, 2'd3};
    for (int k = 0; k < 4; k++) begin
      new_word();
      if (k < 3) sb.push_back(mk(4'b0001, 2'(k), k == 2, deliver(rand_in)));
      else       sb.push_back(mk(4'b0000, 2'd0, 1'b0, 64'h0));
      tick();
      req = 4'b0000;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL burst3 cyc%0d got=%h want=%h", k, obs, e);
      end
    end
  endtask

  // All four requesting with length 1: rotation with bubbles and pointer wrap.
  task automatic test_rr_wrap();
    Reset = 1'b1;
    req = 4'b0000;
    new_word();
    tb_lfsr = 64'h1;
    sb.push_back(mk(4'b0000, 2'd0, 1'b0, 64'h0));
    tick();
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL rr_reset got=%h want=%h", obs, e);
    end
    Reset = 1'b0;
    req = 4'b1111;
    req_len = 8'b01_01_01_01;
    for (int k = 0; k < 10; k++) begin
      new_word();
      if (k == 9) req = 4'b0000;
      if (k % 2 == 0 && k < 9) sb.push_back(mk(4'(1 << ((k / 2) % 4)), 2'd0, 1'b1,
                                               deliver(rand_in)));
      else                    sb.push_back(mk(4'b0000, 2'd0, 1'b0, 64'h0));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rr_wrap cyc%0d got=%h want=%h", k, obs, e);
      end
    end
  endtask

  // A zero length field is a single-word burst.
  task automatic test_len_zero();
    req = 4'b0100;
    req_len = {2'd3, 2'd0, 2'd3, 2'd3};
    for (int k = 0; k < 2; k++) begin
      new_word();
      if (k == 0) sb.push_back(mk(4'b0100, 2'd0, 1'b1, deliver(rand_in)));
      else        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 64'h0));
      tick();
      req = 4'b0000;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL len_zero cyc%0d got=%h want=%h", k, obs, e);
      end
    end
  endtask

  // Reset at out_idx=1 of a 3-word burst, then rr_ptr must be back at 0.
  task automatic test_reset_mid();
    req = 4'b0001;
    req_len = {2'd1, 2'd1, 2'd2, 2'd3};
    for (int k = 0; k < 6; k++) begin
      new_word();
      case (k)
        0: sb.push_back(mk(4'b0001, 2'd0, 1'b0, deliver(rand_in)));
        1: sb.push_back(mk(4'b0001, 2'd1, 1'b0, deliver(rand_in)));
        2: begin
          Reset = 1'b1;
          tb_lfsr = 64'h1;
          sb.push_back(mk(4'b0000, 2'd0, 1'b0, 64'h0));
        end
        3: begin
          Reset = 1'b0;
          req = 4'b1010;
          sb.push_back(mk(4'b0010, 2'd0, 1'b0, deliver(rand_in)));
        end
        4: sb.push_back(mk(4'b0010, 2'd1, 1'b1, deliver(rand_in)));
        default: sb.push_back(mk(4'b0000, 2'd0, 1'b0, 64'h0));
      endcase
      tick();
      if (k >= 3) req = 4'b0000;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid cyc%0d got=%h want=%h", k, obs, e);
      end
    end
  endtask

  // Requesters 0 (len 2) and 1 (len 1) held: alternating bursts, one bubble each.
  task automatic test_back_to_back();
    logic [3:0] g_tab[8];
    logic [1:0] i_tab[8];
    logic       l_tab[8];
    g_tab = '{4'd1, 4'd1, 4'd0, 4'd2, 4'd0, 4'd1, 4'd1, 4'd0};
    i_tab = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    l_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    req = 4'b0011;
    req_len = 8'b00_00_01_10;
    for (int k = 0; k < 8; k++) begin
      new_word();
      if (k == 6) req = 4'b0000;
      if (g_tab[k] != 4'd0) sb.push_back(mk(g_tab[k], i_tab[k], l_tab[k], deliver(rand_in)));
      else                  sb.push_back(mk(4'b0000, 2'd0, 1'b0, 64'h0));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL back_to_back cyc%0d got=%h want=%h", k, obs, e);
      end
    end
  endtask

`ifdef RAND_ARB_WHITEN_EN
  // rand_in held at 0 exposes the raw LFSR sequence 1, 2, 4.
  task automatic test_whiten();
    logic [63:0] w_tab[3];
    w_tab = '{64'h1, 64'h2, 64'h4};
    Reset = 1'b1;
    req = 4'b0000;
    tick();
    Reset = 1'b0;
    tb_lfsr = 64'h1;
    rand_in = 64'h0;
    req = 4'b0001;
    req_len = {2'd1, 2'd1, 2'd1, 2'd3};
    for (int k = 0; k < 3; k++) begin
      sb.push_back(mk(4'b0001, 2'(k), k == 2, w_tab[k]));
      tick();
      req = 4'b0000;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL whiten cyc%0d got=%h want=%h", k, obs, e);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rand_in = '0;
    test_reset();
    test_burst3();
    test_rr_wrap();
    test_len_zero();
    test_reset_mid();
    test_back_to_back();
`ifdef RAND_ARB_WHITEN_EN
    test_whiten();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
